// File: rtl/misc_multicycle_ctrl.sv
// misc_multicycle_ctrl: multicycle control FSM for the 16-bit MISC-V core.
// Sequences fetch / decode / execute / memory / writeback from IR opcode
// bits [2:0], drives the datapath selects and runs the req/ready handshake
// with the unified memory.
// Optional build macro: MISC_CTRL_MEM_TIMEOUT_EN adds a memory-stall
// watchdog that parks the FSM in FAULT and raises a sticky fault flag.
module misc_multicycle_ctrl #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int INSTRET_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [15:0]          instr,
   input  logic                 mem_ready,
   input  logic                 branch_taken,
   input  logic                 halt_req,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 mem_addr_sel,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic [1:0]           pc_src,
   output logic                 alu_src_b,
   output logic                 reg_write,
   output logic [1:0]           wb_sel,
   output logic                 halted,
   output logic                 retire,
   output logic [INSTRET_W-1:0] instret,
   output logic                 fault
);

   localparam logic [3:0] S_RST      = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_EXEC     = 4'd3;
   localparam logic [3:0] S_ALU_WB   = 4'd4;
   localparam logic [3:0] S_MEM_ADDR = 4'd5;
   localparam logic [3:0] S_MEM_RD   = 4'd6;
   localparam logic [3:0] S_LOAD_WB  = 4'd7;
   localparam logic [3:0] S_MEM_WR   = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JUMP     = 4'd10;
   localparam logic [3:0] S_HALT     = 4'd11;
   localparam logic [3:0] S_FAULT    = 4'd12;

   logic [3:0]           r_state;
   logic [3:0]           w_nextState;
   logic [INSTRET_W-1:0] r_instret;
   logic                 w_reqState;
   logic                 w_timeoutHit;
   logic                 w_unusedInstrBits;

   // The upper IR bits carry immediates and register fields; only the
   // immediate generator and register file look at them.
   assign w_unusedInstrBits = ^instr[15:3];

   // States that hold a memory request open; decoded from the state alone so
   // the watchdog never depends on the output logic.
   assign w_reqState = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);

`ifdef MISC_CTRL_MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_timeoutCnt;
   logic             r_fault;
   logic             w_stall;

   assign w_stall      = w_reqState & ~mem_ready;
   assign w_timeoutHit = w_stall & (r_timeoutCnt == TIMEOUT_LAST);
   assign fault        = r_fault;

   // Stall watchdog: counts consecutive unanswered request cycles, restarts
   // whenever a request is answered or none is pending, and latches the fault.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_timeoutCnt <= '0;
         r_fault      <= 1'b0;
      end else begin
         if (w_stall) begin
            r_timeoutCnt <= r_timeoutCnt + CNT_W'(1);
         end else begin
            r_timeoutCnt <= '0;
         end
         if (w_timeoutHit) begin
            r_fault <= 1'b1;
         end
      end
   end
`else
   logic [31:0] w_unusedTimeoutCfg;

   // Without the watchdog the FSM waits on memory forever.
   assign w_unusedTimeoutCfg = 32'(TIMEOUT_CYCLES);
   assign w_timeoutHit       = 1'b0;
   assign fault              = 1'b0;
`endif

   assign instret = r_instret;

   // Next-state and output decode; every instruction's final cycle asserts
   // retire and then heads to HALT or back to FETCH depending on halt_req.
   always_comb begin
      w_nextState  = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      alu_src_b    = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = 2'b00;
      halted       = 1'b0;
      retire       = 1'b0;
      case (r_state)
         S_RST: begin
            w_nextState = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write    = 1'b1;
               pc_write    = 1'b1;
               w_nextState = S_DECODE;
            end
         end
         S_DECODE: begin
            case (instr[2:1])
               2'b00:   w_nextState = S_EXEC;
               2'b01:   w_nextState = S_MEM_ADDR;
               2'b10:   w_nextState = S_BRANCH;
               default: w_nextState = S_JUMP;
            endcase
         end
         S_EXEC: begin
            alu_src_b   = instr[0];
            w_nextState = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write   = 1'b1;
            retire      = 1'b1;
            w_nextState = halt_req ? S_HALT : S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_b   = 1'b1;
            w_nextState = instr[0] ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            if (mem_ready) begin
               w_nextState = S_LOAD_WB;
            end
         end
         S_LOAD_WB: begin
            reg_write   = 1'b1;
            wb_sel      = 2'b01;
            retire      = 1'b1;
            w_nextState = halt_req ? S_HALT : S_FETCH;
         end
         S_MEM_WR: begin
            mem_req      = 1'b1;
            mem_we       = 1'b1;
            mem_addr_sel = 1'b1;
            if (mem_ready) begin
               retire      = 1'b1;
               w_nextState = halt_req ? S_HALT : S_FETCH;
            end
         end
         S_BRANCH: begin
            pc_src      = 2'b01;
            pc_write    = branch_taken;
            retire      = 1'b1;
            w_nextState = halt_req ? S_HALT : S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            retire   = 1'b1;
            if (instr[0]) begin
               reg_write = 1'b1;
               wb_sel    = 2'b10;
            end
            w_nextState = halt_req ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (!halt_req) begin
               w_nextState = S_FETCH;
            end
         end
         S_FAULT: begin
            w_nextState = S_FAULT;
         end
         default: begin
            w_nextState = S_RST;
         end
      endcase
      if (w_reqState && w_timeoutHit) begin
         w_nextState = S_FAULT;
      end
   end

   // State register and retired-instruction counter; the counter wraps
   // silently at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_RST;
         r_instret <= '0;
      end else begin
         r_state <= w_nextState;
         if (retire) begin
            r_instret <= r_instret + INSTRET_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_misc_multicycle_ctrl.sv
// tb_misc_multicycle_ctrl: directed bench for misc_multicycle_ctrl with an
// instruction-step reference model compared every cycle, plus literal checks.
module tb_misc_multicycle_ctrl;

   localparam int IW = 4;
   localparam int TO = 4;
`ifdef MISC_CTRL_MEM_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   localparam logic [12:0] V_ALU_WB  = 13'b0_0_0_0_0_00_0_1_00_0_1;
   localparam logic [12:0] V_LOAD_WB = 13'b0_0_0_0_0_00_0_1_01_0_1;
   localparam logic [12:0] V_STORE   = 13'b1_1_1_0_0_00_0_0_00_0_1;
   localparam logic [12:0] V_BR_T    = 13'b0_0_0_0_1_01_0_0_00_0_1;
   localparam logic [12:0] V_BR_N    = 13'b0_0_0_0_0_01_0_0_00_0_1;
   localparam logic [12:0] V_JAL     = 13'b0_0_0_0_1_10_0_1_10_0_1;
   localparam logic [12:0] V_JMP     = 13'b0_0_0_0_1_10_0_0_00_0_1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   instr;
   logic          mem_ready;
   logic          branch_taken;
   logic          halt_req;
   logic          mem_req;
   logic          mem_we;
   logic          mem_addr_sel;
   logic          ir_write;
   logic          pc_write;
   logic [1:0]    pc_src;
   logic          alu_src_b;
   logic          reg_write;
   logic [1:0]    wb_sel;
   logic          halted;
   logic          retire;
   logic [IW-1:0] instret;
   logic          fault;

   int checks = 0;
   int errors = 0;

   misc_multicycle_ctrl #(
      .TIMEOUT_CYCLES (TO),
      .INSTRET_W      (IW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr        (instr),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .halt_req     (halt_req),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .alu_src_b    (alu_src_b),
      .reg_write    (reg_write),
      .wb_sel       (wb_sel),
      .halted       (halted),
      .retire       (retire),
      .instret      (instret),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   logic [12:0] outVec;
   assign outVec = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                    alu_src_b, reg_write, wb_sel, halted, retire};

   // Reference model: where we are inside the current instruction, counted in
   // steps from the fetch cycle, plus the reset / halt / fault conditions.
   bit            mValid = 1'b0;
   bit            mReset;
   bit            mHalt;
   bit            mFault;
   int            mStep;
   int            mStall;
   logic [IW-1:0] mInstret;
   logic [12:0]   mExp;

   function automatic logic [12:0] modelOut(input bit rs, input bit flt,
                                            input bit hlt, input int step,
                                            input logic [15:0] iv,
                                            input logic rdy, input logic tk);
      logic req = 1'b0, we = 1'b0, asel = 1'b0, irw = 1'b0, pcw = 1'b0;
      logic asb = 1'b0, rw = 1'b0, hl = 1'b0, rt = 1'b0;
      logic [1:0] psrc = 2'b00, wb = 2'b00;
      if (rs || flt) begin
      end else if (hlt) begin
         hl = 1'b1;
      end else if (step == 0) begin
         req = 1'b1;
         irw = rdy;
         pcw = rdy;
      end else if (step >= 2) begin
         case (iv[2:1])
            2'b00: begin
               if (step == 2) asb = iv[0];
               else begin rw = 1'b1; rt = 1'b1; end
            end
            2'b01: begin
               if (step == 2) asb = 1'b1;
               else if (step == 3) begin
                  req = 1'b1; asel = 1'b1; we = iv[0]; rt = iv[0] & rdy;
               end else begin
                  rw = 1'b1; wb = 2'b01; rt = 1'b1;
               end
            end
            2'b10: begin
               psrc = 2'b01; pcw = tk; rt = 1'b1;
            end
            default: begin
               pcw = 1'b1; psrc = 2'b10; rt = 1'b1;
               if (iv[0]) begin rw = 1'b1; wb = 2'b10; end
            end
         endcase
      end
      return {req, we, asel, irw, pcw, psrc, asb, rw, wb, hl, rt};
   endfunction

   assign mExp = modelOut(mReset, mFault, mHalt, mStep, instr, mem_ready,
                          branch_taken);

   // Model advance on each rising edge from the inputs held during the cycle.
   always @(posedge clk) begin
      if (!rst_n) begin
         mValid   <= 1'b1;
         mReset   <= 1'b1;
         mHalt    <= 1'b0;
         mFault   <= 1'b0;
         mStep    <= 0;
         mStall   <= 0;
         mInstret <= '0;
      end else if (mValid) begin
         if (mExp[12] && !mem_ready) mStall <= mStall + 1;
         else mStall <= 0;
         if (mReset) begin
            mReset <= 1'b0;
            mStep  <= 0;
         end else if (mFault) begin
         end else if (mHalt) begin
            if (!halt_req) begin
               mHalt <= 1'b0;
               mStep <= 0;
            end
         end else if (TIMEOUT_ON && mExp[12] && !mem_ready && mStall == TO - 1) begin
            mFault <= 1'b1;
         end else if (mExp[0]) begin
            mInstret <= mInstret + 1'b1;
            mHalt    <= halt_req;
            mStep    <= 0;
         end else if (!(mExp[12] && !mem_ready)) begin
            mStep <= mStep + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: actual 0x%0h required 0x%0h",
                  name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison of the DUT against the model, mid-cycle.
   always @(negedge clk) begin
      if (mValid) begin
         checkOutput("outputs", 32'(outVec), 32'(mExp));
         checkOutput("instret", 32'(instret), 32'(mInstret));
         checkOutput("fault", 32'(fault), 32'(mFault));
      end
   end

   // Runs one instruction starting in its fetch cycle; memory stalls are
   // applied only to data accesses. Returns at the start of the next cycle.
   task automatic applyStimulus(input logic [15:0] iv, input logic taken,
                                input logic halt, input int memStall,
                                output int cycles, output int memCycles,
                                output logic [12:0] lastVec);
      int stallLeft = memStall;
      bit done = 1'b0;
      instr        = iv;
      branch_taken = taken;
      halt_req     = halt;
      cycles       = 0;
      memCycles    = 0;
      lastVec      = '0;
      while (!done && cycles < 50) begin
         if (mem_addr_sel && stallLeft > 0) begin
            mem_ready = 1'b0;
            stallLeft--;
         end else begin
            mem_ready = 1'b1;
         end
         cycles++;
         @(negedge clk);
         if (mem_req && mem_addr_sel) memCycles++;
         if (retire === 1'b1) begin
            done    = 1'b1;
            lastVec = outVec;
         end
         @(posedge clk);
         #1;
      end
      if (!done) checkOutput("retire within budget", 32'(done), 32'd1);
   endtask

   int          cyc;
   int          memCyc;
   logic [12:0] lv;

   initial begin
      rst_n        = 1'b0;
      instr        = 16'h0000;
      mem_ready    = 1'b0;
      branch_taken = 1'b0;
      halt_req     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset outputs", 32'(outVec), 32'd0);
      checkOutput("reset instret", 32'(instret), 32'd0);
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(16'h0000, 1'b0, 1'b0, 0, cyc, memCyc, lv);
      checkOutput("alu cycles", 32'(cyc), 32'd4);
      checkOutput("alu wb outputs", 32'(lv), 32'(V_ALU_WB));
      checkOutput("instret after alu", 32'(instret), 32'd1);

      applyStimulus(16'h0001, 1'b0, 1'b0, 0, cyc, memCyc, lv);
      checkOutput("alu imm cycles", 32'(cyc), 32'd4);

      applyStimulus(16'h0012, 1'b0, 1'b0, 3, cyc, memCyc, lv);
      checkOutput("load cycles", 32'(cyc), 32'd8);
      checkOutput("load request held", 32'(memCyc), 32'd4);
      checkOutput("load wb outputs", 32'(lv), 32'(V_LOAD_WB));

      applyStimulus(16'h0004, 1'b1, 1'b0, 0, cyc, memCyc, lv);
      checkOutput("branch taken cycles", 32'(cyc), 32'd3);
      checkOutput("branch taken outputs", 32'(lv), 32'(V_BR_T));
      applyStimulus(16'h0004, 1'b0, 1'b0, 0, cyc, memCyc, lv);
      checkOutput("branch not-taken cycles", 32'(cyc), 32'd3);
      checkOutput("branch not-taken outputs", 32'(lv), 32'(V_BR_N));

      applyStimulus(16'h0007, 1'b0, 1'b0, 0, cyc, memCyc, lv);
      checkOutput("jal cycles", 32'(cyc), 32'd3);
      checkOutput("jal outputs", 32'(lv), 32'(V_JAL));
      applyStimulus(16'h0006, 1'b0, 1'b0, 0, cyc, memCyc, lv);
      checkOutput("jump outputs", 32'(lv), 32'(V_JMP));

      applyStimulus(16'h0003, 1'b0, 1'b1, 2, cyc, memCyc, lv);
      checkOutput("store cycles", 32'(cyc), 32'd6);
      checkOutput("store request held", 32'(memCyc), 32'd3);
      checkOutput("store retire outputs", 32'(lv), 32'(V_STORE));
      checkOutput("halted after store", 32'(halted), 32'd1);
      checkOutput("no request in halt", 32'(mem_req), 32'd0);
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("halt holds", 32'(halted), 32'd1);
      halt_req = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("fetch after halt", 32'({halted, mem_req}), 32'b01);
      checkOutput("instret before wrap run", 32'(instret), 32'd8);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(16'h0004, 1'b0, 1'b0, 0, cyc, memCyc, lv);
      end
      checkOutput("instret all ones", 32'(instret), 32'hF);
      applyStimulus(16'h0004, 1'b0, 1'b0, 0, cyc, memCyc, lv);
      checkOutput("instret wrap", 32'(instret), 32'd0);
      applyStimulus(16'h0000, 1'b0, 1'b0, 0, cyc, memCyc, lv);

      instr     = 16'h0003;
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("store held while stalled", 32'({mem_req, mem_we}), 32'b11);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset mid store outputs", 32'(outVec), 32'd0);
      checkOutput("reset mid store instret", 32'(instret), 32'd0);

      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("stall fault", 32'(fault), TIMEOUT_ON ? 32'd1 : 32'd0);
      checkOutput("stall request", 32'(mem_req), TIMEOUT_ON ? 32'd0 : 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("fault cleared by reset", 32'(fault), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
